// File: rtl/gpr_wport_arb_pkg.sv
// Shared encodings and widths for the GPR write-port arbiter and its result queue.
package gpr_wport_arb_pkg;

   localparam int unsigned AW   = 5;
   localparam int unsigned DW   = 32;
   localparam int unsigned NREG = 1 << AW;

   localparam logic [AW-1:0] ZERO_REG = '0;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WAIT  = 2'd1,
      ST_STALL = 2'd2
   } arb_state_e;

   function automatic logic [NREG-1:0] reg_onehot(input logic [AW-1:0] a);
      logic [NREG-1:0] m;
      m    = '0;
      m[a] = 1'b1;
      return m;
   endfunction

endpackage

// File: rtl/gpr_wq_fifo.sv
// In-order queue of multiply/divide results {a3, wd} with a registered mask of
// the destination registers held by valid entries.
module gpr_wq_fifo
   import gpr_wport_arb_pkg::*;
#(
   parameter int unsigned DEPTH = 2,
   localparam int unsigned PW   = $clog2(DEPTH),
   localparam int unsigned CNTW = $clog2(DEPTH + 1)
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            push,
   input  logic            pop,
   input  logic [AW-1:0]   push_a3,
   input  logic [DW-1:0]   push_wd,
   output logic [AW-1:0]   head_a3,
   output logic [DW-1:0]   head_wd,
   output logic [CNTW-1:0] count,
   output logic            full,
   output logic            empty,
   output logic [NREG-1:0] pend_mask
);

   logic [AW-1:0]   a3_q [DEPTH];
   logic [AW-1:0]   a3_d [DEPTH];
   logic [DW-1:0]   wd_q [DEPTH];
   logic [DW-1:0]   wd_d [DEPTH];
   logic [PW-1:0]   rptr_q, rptr_d, wptr_q, wptr_d, idx;
   logic [CNTW-1:0] cnt_q, cnt_d;
   logic [NREG-1:0] pend_q, pend_d;
   logic            do_push, do_pop;

   assign full    = (cnt_q == CNTW'(DEPTH));
   assign empty   = (cnt_q == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   assign head_a3   = a3_q[rptr_q];
   assign head_wd   = wd_q[rptr_q];
   assign count     = cnt_q;
   assign pend_mask = pend_q;

   always_comb begin
      a3_d   = a3_q;
      wd_d   = wd_q;
      rptr_d = rptr_q;
      wptr_d = wptr_q;
      cnt_d  = cnt_q;
      pend_d = '0;
      idx    = '0;
      if (do_push) begin
         a3_d[wptr_q] = push_a3;
         wd_d[wptr_q] = push_wd;
         wptr_d       = wptr_q + 1'b1;
      end
      if (do_pop)
         rptr_d = rptr_q + 1'b1;
      case ({do_push, do_pop})
         2'b10:   cnt_d = cnt_q + 1'b1;
         2'b01:   cnt_d = cnt_q - 1'b1;
         default: cnt_d = cnt_q;
      endcase
      // Mask is rebuilt from next-state contents so it moves on the push/pop edge.
      for (int unsigned i = 0; i < DEPTH; i++) begin
         idx = rptr_d + PW'(i);
         if (CNTW'(i) < cnt_d)
            pend_d = pend_d | reg_onehot(a3_d[idx]);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         a3_q   <= '{default: '0};
         wd_q   <= '{default: '0};
         rptr_q <= '0;
         wptr_q <= '0;
         cnt_q  <= '0;
         pend_q <= '0;
      end else begin
         a3_q   <= a3_d;
         wd_q   <= wd_d;
         rptr_q <= rptr_d;
         wptr_q <= wptr_d;
         cnt_q  <= cnt_d;
         pend_q <= pend_d;
      end
   end

endmodule

// File: rtl/gpr_wport_arb.sv
// Shares the GPR write port between writeback (priority) and queued MDU results.
// GPR_WARB_STARVE_EN adds the head-starvation counter and one-cycle stall request.
module gpr_wport_arb
   import gpr_wport_arb_pkg::*;
#(
   parameter int unsigned DEPTH        = 2,
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          wb_we,
   input  logic [AW-1:0] wb_a3,
   input  logic [DW-1:0] wb_wd,
   input  logic          mdu_valid,
   output logic          mdu_ready,
   input  logic [AW-1:0] mdu_a3,
   input  logic [DW-1:0] mdu_wd,
   output logic          gpr_we,
   output logic [AW-1:0] gpr_a3,
   output logic [DW-1:0] gpr_wd,
   output logic          stall_req,
   output logic [31:0]   pend_mask
);

   localparam int unsigned CNTW = $clog2(DEPTH + 1);

   logic            wb_win, head_we, push, q_full, q_empty, q_empty_next;
   logic [AW-1:0]   head_a3;
   logic [DW-1:0]   head_wd;
   logic [CNTW-1:0] q_count;
   arb_state_e      state_q, state_d;

   assign wb_win    = wb_we && (wb_a3 != ZERO_REG);
   assign head_we   = !wb_win && !q_empty;
   assign mdu_ready = !q_full;
   assign push      = mdu_valid && mdu_ready && (mdu_a3 != ZERO_REG);
   // Queue drains this edge: one entry popped, or already empty, and nothing pushed.
   assign q_empty_next = (q_count == CNTW'(head_we)) && !push;

   always_comb begin
      gpr_we = 1'b0;
      gpr_a3 = '0;
      gpr_wd = '0;
      if (wb_win) begin
         gpr_we = 1'b1;
         gpr_a3 = wb_a3;
         gpr_wd = wb_wd;
      end else if (!q_empty) begin
         gpr_we = 1'b1;
         gpr_a3 = head_a3;
         gpr_wd = head_wd;
      end
   end

   gpr_wq_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (push),
      .pop       (head_we),
      .push_a3   (mdu_a3),
      .push_wd   (mdu_wd),
      .head_a3   (head_a3),
      .head_wd   (head_wd),
      .count     (q_count),
      .full      (q_full),
      .empty     (q_empty),
      .pend_mask (pend_mask)
   );

`ifdef GPR_WARB_STARVE_EN
   localparam int unsigned SW = ($clog2(STARVE_LIMIT + 1) > 3) ? $clog2(STARVE_LIMIT + 1) : 3;

   logic [SW-1:0] starve_q, starve_d;

   always_comb begin
      state_d  = state_q;
      starve_d = starve_q;
      case (state_q)
         ST_STALL: begin
            starve_d = '0;
            state_d  = q_empty_next ? ST_IDLE : ST_WAIT;
         end
         default: begin
            if (head_we)
               starve_d = '0;
            else if (!q_empty && wb_win)
               starve_d = starve_q + 1'b1;
            if (q_empty_next)
               state_d = ST_IDLE;
            else if (starve_d == SW'(STARVE_LIMIT))
               state_d = ST_STALL;
            else
               state_d = ST_WAIT;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         starve_q <= '0;
      end else begin
         state_q  <= state_d;
         starve_q <= starve_d;
      end
   end
`else
   always_comb begin
      state_d = q_empty_next ? ST_IDLE : ST_WAIT;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         state_q <= ST_IDLE;
      else
         state_q <= state_d;
   end
`endif

   // Never ST_STALL without the starvation feature, so this ties low there.
   assign stall_req = (state_q == ST_STALL);

endmodule

// File: tb/tb_gpr_wport_arb.sv
// Directed bench for gpr_wport_arb with a scoreboard of queued MDU writes.
module tb_gpr_wport_arb;

   localparam int unsigned DEPTH = 2;
   localparam int unsigned LIMIT = 4;
`ifdef GPR_WARB_STARVE_EN
   localparam bit STARVE_ON = 1'b1;
`else
   localparam bit STARVE_ON = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic        wb_we;
   logic [4:0]  wb_a3;
   logic [31:0] wb_wd;
   logic        mdu_valid;
   logic        mdu_ready;
   logic [4:0]  mdu_a3;
   logic [31:0] mdu_wd;
   logic        gpr_we;
   logic [4:0]  gpr_a3;
   logic [31:0] gpr_wd;
   logic        stall_req;
   logic [31:0] pend_mask;

   typedef struct packed {
      logic [4:0]  a3;
      logic [31:0] wd;
   } ent_t;

   ent_t exp_q[$];
   int   tests = 0;
   int   fails = 0;

   gpr_wport_arb #(
      .DEPTH        (DEPTH),
      .STARVE_LIMIT (LIMIT)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .wb_we     (wb_we),
      .wb_a3     (wb_a3),
      .wb_wd     (wb_wd),
      .mdu_valid (mdu_valid),
      .mdu_ready (mdu_ready),
      .mdu_a3    (mdu_a3),
      .mdu_wd    (mdu_wd),
      .gpr_we    (gpr_we),
      .gpr_a3    (gpr_a3),
      .gpr_wd    (gpr_wd),
      .stall_req (stall_req),
      .pend_mask (pend_mask)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed no finish, expected finish before 200000");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] model_mask();
      logic [31:0] m;
      m = '0;
      foreach (exp_q[i]) m[exp_q[i].a3] = 1'b1;
      return m;
   endfunction

   task automatic drive(input logic we, input logic [4:0] a3, input logic [31:0] wd,
                        input logic mv, input logic [4:0] ma3, input logic [31:0] mwd);
      wb_we     = we;
      wb_a3     = a3;
      wb_wd     = wd;
      mdu_valid = mv;
      mdu_a3    = ma3;
      mdu_wd    = mwd;
   endtask

   // Checks one cycle at the falling edge, then advances the scoreboard past the rising edge.
   task automatic step(input string tag, input logic exp_stall);
      logic        exp_we, pop_now, push_now;
      logic [4:0]  exp_a3;
      logic [31:0] exp_wd;
      @(negedge clk);
      pop_now = 1'b0;
      if (wb_we && wb_a3 != 5'd0) begin
         exp_we = 1'b1; exp_a3 = wb_a3; exp_wd = wb_wd;
      end else if (exp_q.size() > 0) begin
         exp_we = 1'b1; exp_a3 = exp_q[0].a3; exp_wd = exp_q[0].wd; pop_now = 1'b1;
      end else begin
         exp_we = 1'b0; exp_a3 = '0; exp_wd = '0;
      end
      push_now = mdu_valid && (exp_q.size() < DEPTH) && (mdu_a3 != 5'd0);
      chk({tag, ".gpr_we"}, 32'(gpr_we), 32'(exp_we));
      chk({tag, ".gpr_a3"}, 32'(gpr_a3), 32'(exp_a3));
      chk({tag, ".gpr_wd"}, gpr_wd, exp_wd);
      chk({tag, ".mdu_ready"}, 32'(mdu_ready), 32'(exp_q.size() < DEPTH));
      chk({tag, ".pend_mask"}, pend_mask, model_mask());
      chk({tag, ".stall_req"}, 32'(stall_req), 32'(STARVE_ON & exp_stall));
      @(posedge clk);
      #1;
      if (pop_now) void'(exp_q.pop_front());
      if (push_now) exp_q.push_back('{a3: mdu_a3, wd: mdu_wd});
   endtask

   task automatic reset_dut();
      drive(0, 0, 0, 0, 0, 0);
      reset = 1'b1;
      #2;
      reset = 1'b0;
      exp_q.delete();
   endtask

   initial begin
      reset = 1'b1;
      drive(0, 0, 0, 0, 0, 0);
      #2;
      chk("rst.gpr_we", 32'(gpr_we), 32'd0);
      chk("rst.mdu_ready", 32'(mdu_ready), 32'd1);
      chk("rst.stall_req", 32'(stall_req), 32'd0);
      chk("rst.pend_mask", pend_mask, 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;

      // WB alone owns the port
      drive(1, 5, 32'h1234, 0, 0, 0);
      step("wb_only", 0);

      // Idle port: queued result lands one cycle later
      drive(0, 0, 0, 1, 8, 32'hDEADBEEF);
      step("idle_push", 0);
      drive(0, 0, 0, 0, 0, 0);
      step("idle_head", 0);
      chk("idle_head.mask_seen", pend_mask, 32'd0);
      step("idle_after", 0);

      // Full queue under continuous WB
      reset_dut();
      drive(1, 1, 32'h11, 1, 9, 32'hA);
      step("full1", 0);
      drive(1, 1, 32'h12, 1, 10, 32'hB);
      step("full2", 0);
      drive(1, 1, 32'h13, 1, 11, 32'hC);
      step("full3", 0);
      drive(1, 1, 32'h14, 1, 11, 32'hC);
      step("full4", 0);
      drive(0, 0, 0, 0, 0, 0);
      step("full_drain1", 0);
      step("full_drain2", 0);
      step("full_empty", 0);

      // Starvation: stall after LIMIT blocked cycles, again after WB during stall
      reset_dut();
      drive(0, 0, 0, 1, 20, 32'h55);
      step("starve_push", 0);
      for (int i = 0; i < 4; i++) begin
         drive(1, 2, 32'(i + 100), 0, 0, 0);
         step("starve_blk", 0);
      end
      drive(1, 2, 32'h200, 0, 0, 0);
      step("stall_wb_wins", 1);
      for (int i = 0; i < 4; i++) begin
         drive(1, 3, 32'(i + 300), 0, 0, 0);
         step("starve_blk2", 0);
      end
      drive(0, 0, 0, 0, 0, 0);
      step("stall_head_writes", 1);
      step("starve_idle", 0);

      // Register 0 handling
      reset_dut();
      drive(0, 0, 0, 1, 0, 32'h77);
      step("r0_push", 0);
      drive(0, 0, 0, 1, 3, 32'h33);
      step("r0_none_queued", 0);
      drive(1, 0, 32'hFFFF, 0, 0, 0);
      step("r0_wb_yields", 0);
      drive(0, 0, 0, 0, 0, 0);
      step("r0_idle", 0);

      // Back-to-back push with pop keeps occupancy
      reset_dut();
      for (int i = 0; i < 3; i++) begin
         drive(0, 0, 0, 1, 5'(4 + i), 32'(i + 500));
         step("pushpop", 0);
      end
      drive(0, 0, 0, 0, 0, 0);
      step("pushpop_last", 0);
      step("pushpop_idle", 0);

      // Reset mid-operation discards queued results
      reset_dut();
      drive(1, 1, 32'h21, 1, 12, 32'hC0);
      step("mid_fill1", 0);
      drive(1, 1, 32'h22, 1, 13, 32'hC1);
      step("mid_fill2", 0);
      chk("mid_fill2.mask", pend_mask, 32'h0000_3000);
      drive(0, 0, 0, 0, 0, 0);
      reset = 1'b1;
      #1;
      chk("mid_rst.pend_mask", pend_mask, 32'd0);
      chk("mid_rst.mdu_ready", 32'(mdu_ready), 32'd1);
      chk("mid_rst.stall_req", 32'(stall_req), 32'd0);
      chk("mid_rst.gpr_we", 32'(gpr_we), 32'd0);
      exp_q.delete();
      #1;
      reset = 1'b0;
      for (int i = 0; i < 3; i++) step("post_rst", 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/gpr_wport_arb.md
GPR_WPORT_ARB -- requirements
Module: gpr_wport_arb

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- DEPTH, 2, multiply/divide-unit result queue entries (power of two, 2..8).
- STARVE_LIMIT, 4, blocked cycles of the queue head before a pipeline stall is requested.
REQ-002 Ports, one per line: name, direction, width, meaning.
- clk  in  1  single clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- wb_we  in  1  writeback-stage register write request.
- wb_a3  in  5  writeback destination register.
- wb_wd  in  32  writeback data.
- mdu_valid  in  1  multiply/divide unit offers a result.
- mdu_ready  out  1  queue can accept a result.
- mdu_a3  in  5  result destination register.
- mdu_wd  in  32  result data.
- gpr_we  out  1  register-file write enable.
- gpr_a3  out  5  register-file write address.
- gpr_wd  out  32  register-file write data.
- stall_req  out  1  request that the pipeline hold writeback for one cycle.
- pend_mask  out  32  bit n set while a queued result targets register n.

Function
REQ-003 The block SHALL share the single register-file write port between writeback (WB) and the queue head (HEAD); WB has absolute priority.
REQ-004 gpr_we/gpr_a3/gpr_wd SHALL be combinational: WB when wb_we=1 and wb_a3!=0; else HEAD when the queue is non-empty; else gpr_we=0, gpr_a3=0, gpr_wd=0.
REQ-005 A WB write to register 0 SHALL not assert gpr_we and SHALL leave the port free for HEAD that cycle.
REQ-006 A result SHALL be accepted on a rising edge when mdu_valid=1 and mdu_ready=1; mdu_ready = queue not full, registered state only, with no same-cycle push-on-pop when full.
REQ-007 Accepted results with mdu_a3=0 SHALL be discarded without occupying an entry.
REQ-008 Minimum latency from acceptance to gpr_we for that result SHALL be one cycle; results SHALL be written in acceptance order.
REQ-009 HEAD SHALL pop on the edge ending a cycle in which it drove gpr_we.
REQ-010 pend_mask SHALL be the OR of one-hot decoded destinations of all valid entries, registered, and SHALL update on the same edge as push/pop.
REQ-011 FSM states: IDLE (empty), WAIT (non-empty, HEAD blocked count < STARVE_LIMIT), STALL (stall_req=1).
REQ-012 IDLE->WAIT on push; WAIT->IDLE when last entry pops with no push; a 3-bit-or-wider counter increments each cycle HEAD is blocked by WB and clears on HEAD pop.
REQ-013 WAIT->STALL when the counter reaches STARVE_LIMIT; STALL lasts exactly one cycle, then returns to WAIT (or IDLE if emptied) with the counter cleared.
REQ-014 If wb_we=1 during STALL (pipeline contract violation), WB still wins; the counter restarts from 0.
REQ-015 Simultaneous push and pop on a non-full queue SHALL keep the occupancy unchanged and the state unchanged.

Reset
REQ-016 On reset: queue empty, state IDLE, counter 0, mdu_ready=1, stall_req=0, pend_mask=0, gpr_we=0 (unless WB drives it), asynchronously.
REQ-017 Reset mid-operation SHALL discard all queued results.

Configuration
REQ-018 Macro GPR_WARB_STARVE_EN: when defined, the counter, STALL state and stall_req behave per REQ-012..014; when undefined, the counter and STALL are absent, stall_req is tied 0, and HEAD waits indefinitely for a free WB cycle.

Structure
REQ-019 The shared package SHALL hold the FSM state encoding (IDLE/WAIT/STALL), the register-address width (5), the data width (32) and the zero-register constant.
REQ-020 The queue SHALL be a sub-module named gpr_wq_fifo (DEPTH entries of {a3, wd}, count, full/empty); arbitration and FSM stay in the top.

Verification
REQ-021 WB only: wb_we=1, a3=5, wd=0x1234 -> same cycle gpr_we=1, a3=5, wd=0x1234; pend_mask=0.
REQ-022 Idle port: push {a3=8, wd=0xDEADBEEF}, wb_we=0 -> next cycle pend_mask=0x100, gpr_we=1, a3=8; following edge pend_mask=0.
REQ-023 Full: wb_we=1 continuously, push 2 results -> mdu_ready=0; third mdu_valid not accepted; gpr shows WB only.
REQ-024 Starvation (macro on, STARVE_LIMIT=4): one queued result, wb_we=1 for 4 cycles -> stall_req=1 in the 5th cycle; with wb_we=0 then, HEAD writes and state returns to IDLE.
REQ-025 Register 0: push a3=0 -> not queued, pend_mask=0; wb_we=1, wb_a3=0 with queued a3=3 -> gpr_we=1, a3=3 same cycle.
REQ-026 Reset with 2 queued entries -> immediately pend_mask=0, mdu_ready=1, stall_req=0; no queued write reaches gpr afterwards.
